fp_decode: RTL and testbench
============================

FP_DECODE -- requirements
Module: fp_decode

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: S  input  1  sign of the floating-point word (1 = negative).
REQ-004 SHALL have ports: E  input  3  exponent, 0..7.
REQ-005 SHALL have ports: F  input  4  significand, 0..15.
REQ-006 SHALL have ports: in_valid  input  1  S/E/F valid this cycle.
REQ-007 SHALL have ports: in_ready  output  1  block can accept a word.
REQ-008 SHALL have ports: D  output  12  two's-complement linear result.
REQ-009 SHALL have ports: out_valid  output  1  D holds a completed result.
REQ-010 SHALL have ports: out_ready  input  1  consumer accepts D.
REQ-011 SHALL have ports: denorm  output  1  result came from a non-normalized word (E != 0 and F[3] == 0); qualified by out_valid.

Function
REQ-012 SHALL compute magnitude = F << E (11 bits; maximum 15<<7 = 1920, no overflow) and D = S ? -magnitude : magnitude, sign-extended to 12 bits.
REQ-013 SHALL produce D = 0 for F = 0 regardless of S and E (no negative zero).
REQ-014 SHALL implement FSM states IDLE, SHIFT, FORM, HOLD.
REQ-015 SHALL assert in_ready only in IDLE; accept occurs on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL on accept latch S, E and F, load mag = {7'b0, F} and cnt = E, and go to SHIFT if E != 0, otherwise FORM.
REQ-017 SHALL in SHIFT shift mag left by one and decrement cnt each cycle, going to FORM on the cycle cnt reaches 0.
REQ-018 SHALL in FORM register D, denorm and out_valid = 1, then go to HOLD.
REQ-019 SHALL assert out_valid E+2 cycles after the accept edge (iterative build).
REQ-020 SHALL in HOLD keep D, denorm and out_valid stable until out_ready = 1, then clear out_valid and return to IDLE on that edge.
REQ-021 SHALL raise in_ready on the cycle after the output handshake (no same-cycle bypass), even when out_ready is already high as out_valid rises.
REQ-022 SHALL ignore in_valid and S/E/F changes while not in IDLE.
REQ-023 SHALL keep D holding the last delivered value after the handshake until the next FORM.

Reset
REQ-024 SHALL, while rst_n = 0, force state to IDLE and D = 0, out_valid = 0, denorm = 0, in_ready = 0, and clear the internal mag, cnt and sign registers.
REQ-025 SHALL assert in_ready on the first rising edge after rst_n deasserts.
REQ-026 SHALL abandon any operation in progress when reset asserts mid-SHIFT or mid-HOLD, with no result delivered.

Configuration
REQ-027 SHALL, with macro FP_DECODE_BARREL_EN defined, replace SHIFT with a single-cycle barrel shift in the accept-to-FORM path, giving a fixed accept-to-out_valid latency of 2 cycles for all E; the SHIFT state SHALL be unreachable.
REQ-028 SHALL, with FP_DECODE_BARREL_EN undefined, use the iterative E+2-cycle latency; D values SHALL be identical in both builds.

Verification
REQ-029 SHALL cover: S=0, E=3, F=1000 -> D=000001000000 (64), out_valid 5 cycles after accept, denorm=0.
REQ-030 SHALL cover: S=1, E=5, F=1110 -> D=111001000000 (-448); S=1, E=7, F=1111 -> D=100010000000 (-1920).
REQ-031 SHALL cover: S=1, E=0, F=0000 -> D=0, out_valid 2 cycles after accept; S=0, E=2, F=0011 -> D=12, denorm=1.
REQ-032 SHALL cover backpressure: out_ready held low 4 cycles in HOLD -> D and out_valid stable, in_valid pulses ignored with in_ready=0, and in_ready=1 on the cycle after out_ready rises.
REQ-033 SHALL cover: rst_n pulsed low mid-SHIFT of E=7 -> all outputs 0 immediately, no out_valid afterwards, and the next word decodes correctly.
REQ-034 SHALL cover all 256 S/E/F combinations in both builds against a reference model, and check the fixed 2-cycle latency with FP_DECODE_BARREL_EN defined.

Source files
------------

// File: rtl/fp_decode_if.sv
// Word-in / result-out bus for fp_decode.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
// A producer holds its payload while valid is high and ready is low.
interface fp_decode_if;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        denorm;

    modport slave (
        input  S, E, F, in_valid, out_ready,
        output in_ready, D, out_valid, denorm
    );

    modport master (
        output S, E, F, in_valid, out_ready,
        input  in_ready, D, out_valid, denorm
    );
endinterface

// File: rtl/fp_decode.sv
// Tiny float (S, 3-bit E, 4-bit F) to 12-bit two's-complement decoder, iterative shifter.
// Define FP_DECODE_BARREL_EN for a single-cycle barrel shift (fixed 2-cycle latency).
module fp_decode (
    input  logic         clk,
    input  logic         rst_n,
    fp_decode_if.slave   bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FORM = 2'd2, HOLD = 2'd3} state_t;

    state_t      state, state_nxt;
    logic        s_q;
    logic [2:0]  e_q;
    logic [3:0]  f_q;
    logic [2:0]  cnt;
    logic [10:0] mag;
    logic        accept;
    logic [11:0] d_form;
    logic        denorm_form;

    assign state_dbg = state;
    assign accept    = (state == IDLE) && bus.in_valid && bus.in_ready;

    // Negating zero yields zero, so F = 0 never produces a negative zero.
    assign d_form      = s_q ? (12'd0 - {1'b0, mag}) : {1'b0, mag};
    assign denorm_form = (e_q != 3'd0) && !f_q[3];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef FP_DECODE_BARREL_EN
                    state_nxt = FORM;
`else
                    state_nxt = (bus.E != 3'd0) ? SHIFT : FORM;
`endif
                end
            end
            SHIFT: begin
                if (cnt == 3'd1) state_nxt = FORM;
            end
            FORM: state_nxt = HOLD;
            HOLD: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            s_q           <= 1'b0;
            e_q           <= 3'd0;
            f_q           <= 4'd0;
            cnt           <= 3'd0;
            mag           <= 11'd0;
            bus.in_ready  <= 1'b0;
            bus.D         <= 12'd0;
            bus.out_valid <= 1'b0;
            bus.denorm    <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Registered so ready stays low through reset and rises one edge after any return to IDLE.
            bus.in_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_q <= bus.S;
                        e_q <= bus.E;
                        f_q <= bus.F;
                        cnt <= bus.E;
`ifdef FP_DECODE_BARREL_EN
                        mag <= {7'd0, bus.F} << bus.E;
`else
                        mag <= {7'd0, bus.F};
`endif
                    end
                end
                SHIFT: begin
                    mag <= mag << 1;
                    cnt <= cnt - 3'd1;
                end
                FORM: begin
                    bus.D         <= d_form;
                    bus.denorm    <= denorm_form;
                    bus.out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_decode.sv
// Directed and exhaustive bench for fp_decode (both FP_DECODE_BARREL_EN builds).
module tb_fp_decode;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    fp_decode_if bus();

    fp_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_d(input logic s, input logic [2:0] e, input logic [3:0] f);
        int m;
        m = int'(f) * (1 << e);
        if (s) m = -m;
        return m[11:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] e);
`ifdef FP_DECODE_BARREL_EN
        return 2;
`else
        return int'(e) + 2;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait for out_valid and capture the result without completing the handshake.
    // lat counts the accept cycle as 1.
    task automatic send_word(input logic s, input logic [2:0] e, input logic [3:0] f,
                             output logic [11:0] d, output logic dn, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.S = s; bus.E = e; bus.F = f; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
        d  = bus.D;
        dn = bus.denorm;
    endtask

    task automatic finish_handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ov_clear", {31'd0, bus.out_valid}, 32'd0);
        check("ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    endtask

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] d;
        logic        dn;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [11:0] d, dhold;
        logic        dn;
        int          lat;

        vecs[0] = '{1'b0, 3'd3, 4'b1000, 12'h040, 1'b0};
        vecs[1] = '{1'b1, 3'd5, 4'b1110, 12'hE40, 1'b0};
        vecs[2] = '{1'b1, 3'd7, 4'b1111, 12'h880, 1'b0};
        vecs[3] = '{1'b1, 3'd0, 4'b0000, 12'h000, 1'b0};
        vecs[4] = '{1'b0, 3'd2, 4'b0011, 12'h00C, 1'b1};
        vecs[5] = '{1'b1, 3'd3, 4'b0000, 12'h000, 1'b1};
        vecs[6] = '{1'b0, 3'd0, 4'b0101, 12'h005, 1'b0};
        vecs[7] = '{1'b0, 3'd7, 4'b1000, 12'h400, 1'b0};
        vecs[8] = '{1'b1, 3'd1, 4'b0001, 12'hFFE, 1'b1};

        bus.S = 1'b0; bus.E = 3'd0; bus.F = 4'd0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_D", {20'd0, bus.D}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_denorm", {31'd0, bus.denorm}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check("ready_low_before_edge", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("ready_first_edge", {31'd0, bus.in_ready}, 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            send_word(vecs[i].s, vecs[i].e, vecs[i].f, d, dn, lat);
            check($sformatf("vec%0d_D", i), {20'd0, d}, {20'd0, vecs[i].d});
            check($sformatf("vec%0d_denorm", i), {31'd0, dn}, {31'd0, vecs[i].dn});
            check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].e));
            finish_handshake();
        end

        // Backpressure: out_ready low 4 cycles in HOLD, in_valid pulses ignored
        send_word(1'b1, 3'd5, 4'b1110, d, dn, lat);
        dhold = d;
        for (int k = 0; k < 4; k++) begin
            bus.S = k[0]; bus.E = 3'(k + 1); bus.F = 4'(k + 3);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            check("bp_D_stable", {20'd0, bus.D}, {20'd0, dhold});
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        check("bp_D_value", {20'd0, dhold}, 32'hE40);
        finish_handshake();
        check("D_kept_after_hs", {20'd0, bus.D}, 32'hE40);
        tick();
        check("D_kept_idle", {20'd0, bus.D}, 32'hE40);
        send_word(1'b0, 3'd2, 4'b0011, d, dn, lat);
        check("after_bp_D", {20'd0, d}, 32'h00C);
        finish_handshake();

        // out_ready already high as out_valid rises
        bus.out_ready = 1'b1;
        send_word(1'b0, 3'd0, 4'b0101, d, dn, lat);
        check("early_ready_D", {20'd0, d}, 32'h005);
        check("early_ready_ir_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.out_ready = 1'b0;
        check("early_ready_ov_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        check("early_ready_ir_high", {31'd0, bus.in_ready}, 32'd1);

        // Reset mid-SHIFT of E=7 (mid-operation in the barrel build)
        bus.S = 1'b1; bus.E = 3'd7; bus.F = 4'b1111; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_D", {20'd0, bus.D}, 32'd0);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_denorm", {31'd0, bus.denorm}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 15; k++) begin
                tick();
                if (bus.out_valid) seen++;
            end
            check("no_result_after_rst", seen, 32'd0);
        end
        send_word(1'b0, 3'd3, 4'b1000, d, dn, lat);
        check("post_rst_D", {20'd0, d}, 32'h040);
        check("post_rst_lat", lat, exp_lat(3'd3));

        // Reset mid-HOLD
        rst_n = 1'b0;
        #1;
        check("holdrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("holdrst_D", {20'd0, bus.D}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Exhaustive sweep against reference model, results queued then matched
        for (int i = 0; i < 256; i++) begin
            logic [7:0] w;
            w = 8'(i);
            exp_q.push_back(ref_d(w[7], w[6:4], w[3:0]));
            send_word(w[7], w[6:4], w[3:0], d, dn, lat);
            check("sweep_D", {20'd0, d}, {20'd0, exp_q.pop_front()});
            check("sweep_denorm", {31'd0, dn}, {31'd0, (w[6:4] != 3'd0) && !w[3]});
            check("sweep_lat", lat, exp_lat(w[6:4]));
            finish_handshake();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
